// File: rtl/wdt_reg_if_if.sv
// -----------------------------------------------------------------------------
// wdt_reg_if_if
// Simple register bus between a system-clock master and the watchdog register
// front end (wdt_reg_if).
//
// Signals:
//   wr_en    - write strobe, one cycle per write (master -> slave)
//   rd_en    - read strobe, one cycle per read (master -> slave)
//   addr     - byte address, bits [1:0] are ignored by the slave
//   wdata    - write data (master -> slave)
//   rdata    - read data, valid while rd_valid=1 (slave -> master)
//   rd_valid - read response strobe, one cycle after rd_en (slave -> master)
// -----------------------------------------------------------------------------
interface wdt_reg_if_if #(
  parameter int ADDR_W = 5
);
  logic              wr_en;
  logic              rd_en;
  logic [ADDR_W-1:0] addr;
  logic [31:0]       wdata;
  logic [31:0]       rdata;
  logic              rd_valid;

  modport master (
    output wr_en,
    output rd_en,
    output addr,
    output wdata,
    input  rdata,
    input  rd_valid
  );

  modport slave (
    input  wr_en,
    input  rd_en,
    input  addr,
    input  wdata,
    output rdata,
    output rd_valid
  );
endinterface

// File: rtl/wdt_reg_if.sv
// -----------------------------------------------------------------------------
// wdt_reg_if
// System-clock register front end for the watchdog timer.
//   - Decodes bus writes/reads into WDEN, the WDLIVE kick and the WTOCNT
//     reload value.
//   - Stretches every kick into a LIVE_HOLD-cycle high pulse followed by at
//     least LIVE_GAP low cycles so the slower timer clock always sees it.
//     One extra kick can be queued while a pulse is in flight.
//   - Brings the asynchronous WTO back through a two-flop synchronizer and
//     an edge detector into a sticky TO status bit that also drives irq.
//
// Register map (byte addresses, addr[1:0] ignored):
//   0x00 CTRL   bit0 WDEN (R/W)
//   0x04 LIVE   any write requests a kick, reads 0
//   0x08 WTOCNT reload value (R/W, writes only take effect while WDEN=0)
//   0x0C STATUS bit0 TO (W1C), bit1 BUSY (RO), bit2 ERR (W1C)
//   0x10 LOCK   lock bit when WDT_LOCK_EN is defined, otherwise reads 0
//
// Optional feature: define WDT_LOCK_EN to build the register lock. Writing
// 0x1ACCE551 to LOCK unlocks, any other value locks; while locked, CTRL and
// WTOCNT writes are dropped and flag ERR.
//
// Ports:
//   clk    - system clock
//   rst    - synchronous active-high reset
//   bus    - register bus (slave side)
//   WDEN   - watchdog enable level to the timer
//   WDLIVE - stretched kick pulse to the timer
//   WTOCNT - timeout reload value to the timer
//   WTO    - timeout from the timer, asynchronous to clk
//   irq    - timeout interrupt (level, equals STATUS.TO)
// -----------------------------------------------------------------------------
module wdt_reg_if #(
  parameter int LIVE_HOLD = 4,
  parameter int LIVE_GAP  = 4,
  parameter int ADDR_W    = 5
) (
  input  logic        clk,
  input  logic        rst,
  wdt_reg_if_if.slave bus,
  output logic        WDEN,
  output logic        WDLIVE,
  output logic [31:0] WTOCNT,
  input  logic        WTO,
  output logic        irq
);

  // Word address width and register offsets
  localparam int WA_W = ADDR_W - 2;
  localparam logic [WA_W-1:0] WA_CTRL   = WA_W'(3'd0);
  localparam logic [WA_W-1:0] WA_LIVE   = WA_W'(3'd1);
  localparam logic [WA_W-1:0] WA_WTOCNT = WA_W'(3'd2);
  localparam logic [WA_W-1:0] WA_STATUS = WA_W'(3'd3);
  localparam logic [WA_W-1:0] WA_LOCK   = WA_W'(3'd4);

  // Pulse counter sized for the larger of the hold and gap lengths
  localparam int CNT_MAX = (LIVE_HOLD > LIVE_GAP) ? LIVE_HOLD : LIVE_GAP;
  localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
  localparam logic [CNT_W-1:0] HOLD_LOAD = CNT_W'(LIVE_HOLD - 1);
  localparam logic [CNT_W-1:0] GAP_LOAD  = CNT_W'(LIVE_GAP - 1);
  localparam logic [CNT_W-1:0] CNT_ZERO  = CNT_W'(1'b0);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1'b1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_HOLD = 2'd1,
    ST_GAP  = 2'd2
  } kick_state_e;

  // Register state
  logic              wden_q,     wden_d;
  logic [31:0]       wtocnt_q,   wtocnt_d;
  logic              to_q,       to_d;
  logic              err_q,      err_d;
  logic [31:0]       rdata_q,    rdata_d;
  logic              rd_valid_q, rd_valid_d;

  // Kick pulse stretcher state
  kick_state_e       state_q,    state_d;
  logic [CNT_W-1:0]  cnt_q,      cnt_d;
  logic              pend_q,     pend_d;
  logic              wdlive_q,   wdlive_d;

  // WTO synchronizer and edge detector
  logic [1:0]        wto_sync_q, wto_sync_d;
  logic              wto_prev_q, wto_prev_d;

  // Decode and helper signals
  logic [WA_W-1:0]   wa_s;
  logic              unused_addr_s;
  logic              wr_ctrl_s;
  logic              wr_live_s;
  logic              wr_wtocnt_s;
  logic              wr_status_s;
  logic              wr_lock_s;
  logic              locked_s;
  logic              busy_s;
  logic              wto_rise_s;
  logic              err_set_s;
  logic              err_clr_s;
  logic              to_clr_s;
  logic [31:0]       rd_mux_s;

  assign wa_s          = bus.addr[ADDR_W-1:2];
  assign unused_addr_s = ^bus.addr[1:0];

  assign wr_ctrl_s   = bus.wr_en && (wa_s == WA_CTRL);
  assign wr_live_s   = bus.wr_en && (wa_s == WA_LIVE);
  assign wr_wtocnt_s = bus.wr_en && (wa_s == WA_WTOCNT);
  assign wr_status_s = bus.wr_en && (wa_s == WA_STATUS);
  assign wr_lock_s   = bus.wr_en && (wa_s == WA_LOCK);

  assign busy_s     = (state_q != ST_IDLE);
  assign wto_rise_s = wto_sync_q[1] & ~wto_prev_q;

`ifdef WDT_LOCK_EN
  localparam logic [31:0] UNLOCK_KEY = 32'h1ACC_E551;

  logic lock_q, lock_d;

  // Lock bit: the unlock key clears it, any other value written sets it
  always_comb begin
    lock_d = lock_q;
    if (wr_lock_s) begin
      lock_d = (bus.wdata != UNLOCK_KEY);
    end else begin
      lock_d = lock_q;
    end
  end

  // Lock bit register
  always_ff @(posedge clk) begin
    if (rst) begin
      lock_q <= 1'b0;
    end else begin
      lock_q <= lock_d;
    end
  end

  assign locked_s = lock_q;
`else
  assign locked_s = 1'b0;
`endif

  // Control, reload and sticky status next-state
  always_comb begin
    wden_d   = wden_q;
    wtocnt_d = wtocnt_q;

    if (wr_ctrl_s && !locked_s) begin
      wden_d = bus.wdata[0];
    end else begin
      wden_d = wden_q;
    end

    // The reload value is only allowed to change while the timer is stopped
    if (wr_wtocnt_s && !locked_s && !wden_q) begin
      wtocnt_d = bus.wdata;
    end else begin
      wtocnt_d = wtocnt_q;
    end

    err_set_s = (wr_ctrl_s && locked_s) || (wr_wtocnt_s && (locked_s || wden_q));
    err_clr_s = wr_status_s && bus.wdata[2];
    to_clr_s  = wr_status_s && bus.wdata[0];

    // A set arriving with a W1C clear wins so no event is lost
    err_d = err_set_s  | (err_q & ~err_clr_s);
    to_d  = wto_rise_s | (to_q  & ~to_clr_s);

    wto_sync_d = {wto_sync_q[0], WTO};
    wto_prev_d = wto_sync_q[1];
  end

  // Read data mux from the current (pre-write) register values
  always_comb begin
    rd_mux_s = 32'd0;
    case (wa_s)
      WA_CTRL:   rd_mux_s = {31'd0, wden_q};
      WA_LIVE:   rd_mux_s = 32'd0;
      WA_WTOCNT: rd_mux_s = wtocnt_q;
      WA_STATUS: rd_mux_s = {29'd0, err_q, busy_s, to_q};
      WA_LOCK:   rd_mux_s = {31'd0, locked_s};
      default:   rd_mux_s = 32'd0;
    endcase

    rd_valid_d = bus.rd_en;
    if (bus.rd_en) begin
      rdata_d = rd_mux_s;
    end else begin
      rdata_d = rdata_q;
    end
  end

  // Kick stretcher next-state: HOLD drives WDLIVE, GAP guarantees low time
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    pend_d   = pend_q;
    wdlive_d = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (wr_live_s || pend_q) begin
          state_d  = ST_HOLD;
          cnt_d    = HOLD_LOAD;
          pend_d   = 1'b0;
          wdlive_d = 1'b1;
        end else begin
          state_d  = ST_IDLE;
        end
      end
      ST_HOLD: begin
        wdlive_d = 1'b1;
        if (cnt_q == CNT_ZERO) begin
          state_d  = ST_GAP;
          cnt_d    = GAP_LOAD;
          wdlive_d = 1'b0;
        end else begin
          cnt_d    = cnt_q - CNT_ONE;
        end
        // Only one kick is queued; a request while one is pending is dropped
        if (wr_live_s) begin
          pend_d = 1'b1;
        end else begin
          pend_d = pend_q;
        end
      end
      ST_GAP: begin
        if (cnt_q == CNT_ZERO) begin
          // A request on the final gap cycle counts as pending and restarts
          if (pend_q || wr_live_s) begin
            state_d  = ST_HOLD;
            cnt_d    = HOLD_LOAD;
            pend_d   = 1'b0;
            wdlive_d = 1'b1;
          end else begin
            state_d  = ST_IDLE;
          end
        end else begin
          cnt_d = cnt_q - CNT_ONE;
          if (wr_live_s) begin
            pend_d = 1'b1;
          end else begin
            pend_d = pend_q;
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = CNT_ZERO;
        pend_d  = 1'b0;
      end
    endcase
  end

  // All registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      wden_q     <= 1'b0;
      wtocnt_q   <= 32'd0;
      to_q       <= 1'b0;
      err_q      <= 1'b0;
      rdata_q    <= 32'd0;
      rd_valid_q <= 1'b0;
      state_q    <= ST_IDLE;
      cnt_q      <= CNT_ZERO;
      pend_q     <= 1'b0;
      wdlive_q   <= 1'b0;
      wto_sync_q <= 2'b00;
      wto_prev_q <= 1'b0;
    end else begin
      wden_q     <= wden_d;
      wtocnt_q   <= wtocnt_d;
      to_q       <= to_d;
      err_q      <= err_d;
      rdata_q    <= rdata_d;
      rd_valid_q <= rd_valid_d;
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      pend_q     <= pend_d;
      wdlive_q   <= wdlive_d;
      wto_sync_q <= wto_sync_d;
      wto_prev_q <= wto_prev_d;
    end
  end

  assign bus.rdata    = rdata_q;
  assign bus.rd_valid = rd_valid_q;
  assign WDEN         = wden_q;
  assign WTOCNT       = wtocnt_q;
  assign WDLIVE       = wdlive_q;
  assign irq          = to_q;

endmodule

// File: doc/wdt_reg_if.md
Name: wdt_reg_if

Overview:
System-clock register front end for the watchdog timer.
- Decodes simple bus writes and reads into the timer's control inputs: WDEN level, WDLIVE kick pulse, WTOCNT reload value.
- Stretches each kick into a fixed-width pulse with a guaranteed low gap, so the slower timer clock domain always captures it.
- Synchronizes the timer's WTO output back into the system clock domain as a sticky status bit and a level interrupt.

Parameters:
- LIVE_HOLD, 4: clk cycles WDLIVE is held high per kick (≥1).
- LIVE_GAP, 4: minimum clk cycles WDLIVE is held low between kicks (≥1).
- ADDR_W, 5: byte address width.

Ports:
- clk, input, 1: system clock.
- rst, input, 1: reset; synchronous, active-high.
- wr_en, input, 1: write strobe, one cycle per write.
- rd_en, input, 1: read strobe, one cycle per read.
- addr, input, ADDR_W: byte address; bits [1:0] ignored.
- wdata, input, 32: write data.
- rdata, output, 32: read data, valid when rd_valid=1.
- rd_valid, output, 1: read response strobe.
- WDEN, output, 1: watchdog enable level to the timer.
- WDLIVE, output, 1: stretched kick pulse to the timer.
- WTOCNT, output, 32: timeout reload value to the timer.
- WTO, input, 1: timeout from the timer; asynchronous to clk.
- irq, output, 1: timeout interrupt, level.

Behaviour:
- Reset (clk edge with rst=1): every output and every internal register is 0; FSM goes to IDLE; kick pending flag is cleared.
- Register map:
  - 0x00 CTRL: bit0 = WDEN; R/W.
  - 0x04 LIVE: any write requests a kick; reads return 0.
  - 0x08 WTOCNT: R/W.
  - 0x0C STATUS: bit0 TO (sticky, W1C); bit1 BUSY (FSM not IDLE, RO); bit2 ERR (sticky, W1C).
  - 0x10 LOCK: see Optional Feature.
  - Unmapped addresses: reads return 0; writes are ignored.
- Reads: rdata and rd_valid register one cycle after rd_en. When idle, rdata is held at its last value and rd_valid=0.
- Simultaneous rd_en and wr_en: the read returns the pre-write value.
- Write to WTOCNT while WDEN=1: value is ignored and ERR is set. The count changes only while the timer is disabled.
- WDEN and WTOCNT drive straight from their registers and update the cycle after the write.
- Kick FSM (states IDLE, HOLD, GAP):
  - IDLE: a kick request, or a pending kick, moves to HOLD. WDLIVE=1 from the next cycle; hold counter loads LIVE_HOLD-1.
  - HOLD: WDLIVE=1 while counting down. At 0, move to GAP; counter loads LIVE_GAP-1.
  - GAP: WDLIVE=0 while counting down. At 0, move to IDLE. If the pending flag is set, go directly to HOLD instead and clear the flag.
  - Kick request in HOLD or GAP sets the pending flag. At most one kick is queued; further requests are dropped.
  - A kick while WDEN=0 is still issued.
  - Clearing WDEN does not abort a pulse already in progress.
- WTO path:
  - Two-flop synchronizer, then an edge detector.
  - A synchronized rising edge sets TO.
  - irq equals TO.
  - TO set on the same cycle as a W1C clear: set wins.
  - ERR set on the same cycle as a W1C clear: set wins.
- Reset mid-pulse drops WDLIVE to 0 on the next edge and clears the pending flag.

Optional Feature:
Macro WDT_LOCK_EN.
- Defined:
  - Internal lock bit, reset 0 (unlocked).
  - Write 0x1ACCE551 to LOCK: unlocks. Any other value written to LOCK: locks.
  - While locked, CTRL and WTOCNT writes are ignored and set ERR. LIVE and STATUS writes are still accepted.
  - LOCK reads return bit0 = lock.
- Not defined: LOCK reads return 0; LOCK writes are ignored; no lock logic is built.

Test Plan:
- Reset, then read 0x00/0x08/0x0C → each returns 0, one cycle after rd_en. WDEN=0, WDLIVE=0, irq=0.
- Write WTOCNT=0x100, then CTRL=1 → WTOCNT=0x100 and WDEN=1 the cycle after each write. Then write WTOCNT=0x5 → WTOCNT stays 0x100; STATUS reads 0x4.
- Write LIVE once (defaults) → WDLIVE high exactly 4 cycles, then low ≥4 cycles. BUSY=1 throughout; BUSY=0 after cycle 8.
- Write LIVE on 3 consecutive cycles → exactly 2 pulses of 4 cycles high, separated by 4 low cycles.
- Raise WTO for 1 cycle → irq=1 three clk cycles later. Write STATUS=0x1 → irq=0 next cycle. Repeat the clear on the same cycle as a new synchronized edge → irq stays 1.
- With WDT_LOCK_EN: write LOCK=0, then CTRL=1 → WDEN stays 0; ERR=1. Write LOCK=0x1ACCE551, then CTRL=1 → WDEN=1.
